// File: rtl/parity_checker_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : parity_checker_rx_if
// Brief    : Serial-line and received-word bundle for parity_checker_rx.
// Revision : 1.0  initial release
// ============================================================================
interface parity_checker_rx_if #(
  parameter int DATA_W = 8
);
  logic              bit_en;
  logic              serial_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
  logic [7:0]        err_count;

  modport master (
    output bit_en, serial_in,
    input  data_out, data_valid, parity_err, frame_err, busy, err_count
  );

  modport slave (
    input  bit_en, serial_in,
    output data_out, data_valid, parity_err, frame_err, busy, err_count
  );
endinterface
`default_nettype wire

// File: rtl/parity_checker_rx.sv
`default_nettype none
// ============================================================================
// Module   : parity_checker_rx
// Brief    : Strobed serial receiver (start, LSB-first data, parity, stop)
//            with parity/framing checks and a saturating error counter.
// Revision : 1.0  initial release
// ============================================================================
module parity_checker_rx #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  parity_checker_rx_if.slave   bus
);

  localparam int                c_IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_W - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_PARITY = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_IDX_W-1:0]  r_idx;
  logic [c_IDX_W-1:0]  w_idx_nxt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic                r_xor;
  logic                w_xor_nxt;
  logic                w_done;
  logic                w_ferr;
  logic                w_perr;

  logic [DATA_W-1:0]   r_data_out;
  logic                r_valid;
  logic                r_perr;
  logic                r_ferr;
  logic [7:0]          r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // r_xor accumulates data bits and then the parity bit, so at STOP it
  // already holds the full even-parity syndrome.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_xor_nxt   = r_xor;
    w_done      = 1'b0;
    w_ferr      = 1'b0;
    if (bus.bit_en) begin
      unique case (r_state)
        S_IDLE: begin
          if (!bus.serial_in) begin
            w_state_nxt = S_DATA;
            w_idx_nxt   = '0;
            w_xor_nxt   = 1'b0;
          end
        end
        S_DATA: begin
          w_shift_nxt[r_idx] = bus.serial_in;
          w_xor_nxt          = r_xor ^ bus.serial_in;
          if (r_idx == c_LAST_IDX) begin
            w_state_nxt = S_PARITY;
          end else begin
            w_idx_nxt = r_idx + c_IDX_ONE;
          end
        end
        S_PARITY: begin
          w_xor_nxt   = r_xor ^ bus.serial_in;
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          w_done      = 1'b1;
          w_ferr      = ~bus.serial_in;
          w_state_nxt = bus.serial_in ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          if (bus.serial_in) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign w_perr = r_xor ^ ODD_PARITY;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_shift    <= '0;
      r_xor      <= 1'b0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_err_cnt  <= 8'd0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_xor   <= w_xor_nxt;
      r_valid <= w_done;
      if (w_done) begin
        r_data_out <= r_shift;
        r_perr     <= w_perr;
        r_ferr     <= w_ferr;
        if ((w_perr || w_ferr) && (r_err_cnt != 8'hFF)) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_valid;
  assign bus.parity_err = r_perr;
  assign bus.frame_err  = r_ferr;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.err_count  = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/parity_checker_rx.md
# parity_checker_rx

Serial receiver and parity checker, the receive-side counterpart of the combinational parity generator. Deserialises frames of one start bit, DATA_W data bits (LSB first), one parity bit and one stop bit from a single serial line, checks parity and framing, and presents the word with a one-cycle valid strobe. The block sits at the serial input of the design, ahead of any consumer of received bytes. It keeps a saturating error counter for link monitoring.

## Interface
Parameters:
- DATA_W, 8, number of data bits per frame (legal range 2..16).
- ODD_PARITY, 0, parity sense: 0 means even parity, 1 means odd parity.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_en  input  1  bit strobe; serial_in is sampled only in cycles with bit_en=1.
- serial_in  input  1  serial line; idles high.
- data_out  output  DATA_W  last received word; holds until the next frame completes.
- data_valid  output  1  one-cycle pulse when a frame completes.
- parity_err  output  1  parity mismatch for the frame in data_out; held with data_out.
- frame_err  output  1  stop bit sampled 0 for the frame in data_out; held with data_out.
- busy  output  1  high whenever the FSM is not in IDLE.
- err_count  output  8  number of erroneous frames, saturating at 255.

## Operation
- FSM states:
  - IDLE: on bit_en with serial_in=0 (start bit), go to DATA with the bit index cleared.
  - DATA: on each bit_en, shift serial_in into the data register at the current index (LSB first) and fold it into the running XOR. After DATA_W bits, go to PARITY.
  - PARITY: on bit_en, capture the parity bit, then go to STOP.
  - STOP: on bit_en, sample the stop bit and complete the frame.
    - Stop bit 1: go to IDLE.
    - Stop bit 0: go to BREAK.
  - BREAK: wait for a bit_en sample with serial_in=1, then go to IDLE. A low line is never taken as a new start bit until a high sample has been seen.
- Cycles with bit_en=0 hold all state.
- Parity check: err = XOR(data bits, parity bit) XOR ODD_PARITY. A nonzero result sets parity_err.
- Frame completion (the STOP sample edge):
  - data_out, parity_err and frame_err are loaded.
  - data_valid=1 for exactly one cycle.
  - A frame with frame_err is still reported, with data_valid=1.
- err_count increments by 1 per completed frame where parity_err or frame_err is set. A frame with both errors counts once. The counter holds at 255.
- Reset (rst=1 at any edge, including mid-frame):
  - FSM goes to IDLE and the partial frame is discarded; no data_valid is produced.
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, err_count=0.
  - bit_en is ignored while rst=1.

## Timing
- A frame occupies 3+DATA_W bit_en samples (11 for DATA_W=8).
- data_valid is high in the cycle immediately after the edge that samples the stop bit. data_out, parity_err and frame_err are valid in that same cycle.
- busy rises the cycle after the start-bit sample. It falls the same cycle data_valid rises, or after the BREAK exit sample.
- Back-to-back frames: a start bit may be sampled on the bit_en immediately after the stop bit. There is no idle gap requirement and no lost frame.
- bit_en may be held at 1 continuously (one bit per clock) or be sparse and irregular; behaviour depends only on the sampled sequence.
- There is no backpressure. A consumer that misses the data_valid pulse loses the frame.

## Test plan
- Reset state: assert rst for 2 cycles, then check every output is 0 and busy=0. Drive idle line with bit_en=1 for 5 cycles, then check no data_valid.
- Good frame: DATA_W=8, even parity, bit_en=1 continuous. Send start 0, data 1,0,1,0,0,1,0,1 (0xA5), parity 0, stop 1.
  - One cycle after stop, expect data_valid=1, data_out=0xA5, parity_err=0, frame_err=0.
  - Expect err_count=0 and busy=0.
- Parity error: send 0x07 with parity 0 (correct value is 1). Expect data_out=0x07, parity_err=1, frame_err=0, err_count=1.
- Framing error and BREAK: send 0x3C with correct parity 0 and stop 0, then hold serial_in=0 for 4 bit_en samples, then 1.
  - Expect frame_err=1 and err_count to increment.
  - Expect no new frame to start while the line is low.
  - Expect IDLE after the high sample.
- Sparse strobe and back-to-back frames:
  - Send 0x55 then 0xAA (both correct even parity, bit_en every 3rd cycle), with the second start bit sampled on the bit_en after the first stop bit.
  - Expect two data_valid pulses, 33 cycles apart, with the correct data and no errors.
- Mid-frame reset and saturation:
  - Assert rst after 4 data bits. Expect no data_valid, and a following good frame 0x81 received correctly.
  - Separately, send 260 parity-error frames. Expect err_count=255 and held there.
